mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 26 ++
 rtl/mem_req_arbiter_if.sv | 59 +++++
 rtl/mem_req_arbiter_req_prio_sel.sv | 41 ++++
 rtl/mem_req_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared defines for the memory request arbiter: timer addresses, access size
// codes, FSM state encoding and request-owner tags.
package mem_req_arbiter_pkg;

    localparam logic [63:0] ADDR_MTIME    = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] ADDR_MTIMECMP = 64'h0000_0000_0200_4000;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        TMR_REQ,
        RSP
    } arb_state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the IFU/LSU request-response, memory and timer signals.
// The arbiter uses the slave modport; the surrounding system uses master.
interface mem_req_arbiter_if;

    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_req_addr;
    logic [2:0]  if_req_size;
    logic        if_rsp_valid;
    logic [63:0] if_rsp_data;

    logic        ls_req_valid;
    logic        ls_req_ready;
    logic        ls_req_wen;
    logic [63:0] ls_req_addr;
    logic [2:0]  ls_req_size;
    logic [63:0] ls_req_wdata;
    logic [7:0]  ls_req_wmask;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_data;

    logic        mem_cen;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [2:0]  mem_size;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    logic        tmr_cen;
    logic        tmr_wen;
    logic [63:0] tmr_addr;
    logic [63:0] tmr_wdata;
    logic [63:0] tmr_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_req_size,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_valid, ls_req_wen, ls_req_addr, ls_req_size, ls_req_wdata, ls_req_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_cen, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_size,
        input  mem_ready, mem_rdata,
        output tmr_cen, tmr_wen, tmr_addr, tmr_wdata,
        input  tmr_rdata
    );

    modport master (
        output if_req_valid, if_req_addr, if_req_size,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_valid, ls_req_wen, ls_req_addr, ls_req_size, ls_req_wdata, ls_req_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_cen, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_size,
        output mem_ready, mem_rdata,
        input  tmr_cen, tmr_wen, tmr_addr, tmr_wdata,
        output tmr_rdata
    );

endinterface

// File: rtl/mem_req_arbiter_req_prio_sel.sv
// Grant selection between IFU and LSU: LSU has priority, but after STARVE_MAX
// consecutive LSU grants with the IFU waiting, the IFU is granted once.
module req_prio_sel #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_valid,
    input  logic ls_valid,
    output logic if_ready,
    output logic ls_ready
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0] starve_cnt_q, starve_cnt_d;
    logic       if_win;

    always_comb begin
        if_win       = if_valid && (!ls_valid || starve_cnt_q == STARVE_LIM);
        if_ready     = idle && if_win;
        ls_ready     = idle && ls_valid && !if_win;
        starve_cnt_d = starve_cnt_q;
        // ready implies valid, so a ready output is the grant itself
        if (if_ready) begin
            starve_cnt_d = '0;
        end else if (ls_ready && if_valid && starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter routing IFU/LSU requests to memory, or LSU
// accesses at the timer addresses to the timer port, with registered outputs.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX    = 4,
    parameter logic [63:0] MTIME_ADDR    = ADDR_MTIME,
    parameter logic [63:0] MTIMECMP_ADDR = ADDR_MTIMECMP
) (
    input  logic             clk,
    input  logic             rst,
    mem_req_arbiter_if.slave bus
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        wen_q, wen_d;
    logic        mem_cen_q, mem_cen_d;
    logic        tmr_cen_q, tmr_cen_d;
    logic        if_rsp_valid_q, if_rsp_valid_d;
    logic        ls_rsp_valid_q, ls_rsp_valid_d;
    logic        idle, if_ready, ls_ready, ls_to_tmr;

    assign idle      = (state_q == IDLE);
    assign ls_to_tmr = (bus.ls_req_addr == MTIME_ADDR) || (bus.ls_req_addr == MTIMECMP_ADDR);

    req_prio_sel #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .idle    (idle),
        .if_valid(bus.if_req_valid),
        .ls_valid(bus.ls_req_valid),
        .if_ready(if_ready),
        .ls_ready(ls_ready)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        size_d         = size_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        rsp_data_d     = rsp_data_q;
        mem_cen_d      = mem_cen_q;
        tmr_cen_d      = 1'b0;
        if_rsp_valid_d = 1'b0;
        ls_rsp_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_ready) begin
                    owner_d   = OWN_IFU;
                    addr_d    = bus.if_req_addr;
                    size_d    = bus.if_req_size;
                    wen_d     = 1'b0;
                    wdata_d   = '0;
                    wmask_d   = '0;
                    mem_cen_d = 1'b1;
                    state_d   = MEM_REQ;
                end else if (ls_ready) begin
                    owner_d = OWN_LSU;
                    addr_d  = bus.ls_req_addr;
                    size_d  = bus.ls_req_size;
                    wen_d   = bus.ls_req_wen;
                    wdata_d = bus.ls_req_wdata;
                    wmask_d = bus.ls_req_wmask;
                    if (ls_to_tmr) begin
                        tmr_cen_d = 1'b1;
                        state_d   = TMR_REQ;
                    end else begin
                        mem_cen_d = 1'b1;
                        state_d   = MEM_REQ;
                    end
                end
            end
            MEM_REQ: state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    mem_cen_d      = 1'b0;
                    rsp_data_d     = bus.mem_rdata;
                    if_rsp_valid_d = (owner_q == OWN_IFU);
                    ls_rsp_valid_d = (owner_q == OWN_LSU);
                    state_d        = RSP;
                end
            end
            TMR_REQ: begin
                rsp_data_d     = bus.tmr_rdata;
                if_rsp_valid_d = (owner_q == OWN_IFU);
                ls_rsp_valid_d = (owner_q == OWN_LSU);
                state_d        = RSP;
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IFU;
            addr_q         <= '0;
            size_q         <= '0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            rsp_data_q     <= '0;
            mem_cen_q      <= 1'b0;
            tmr_cen_q      <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            wen_q          <= wen_d;
            wdata_q        <= wdata_d;
            wmask_q        <= wmask_d;
            rsp_data_q     <= rsp_data_d;
            mem_cen_q      <= mem_cen_d;
            tmr_cen_q      <= tmr_cen_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
        end
    end

    // Memory and timer ports share the latched request registers.
    assign bus.if_req_ready = if_ready;
    assign bus.ls_req_ready = ls_ready;
    assign bus.if_rsp_valid = if_rsp_valid_q;
    assign bus.if_rsp_data  = rsp_data_q;
    assign bus.ls_rsp_valid = ls_rsp_valid_q;
    assign bus.ls_rsp_data  = rsp_data_q;
    assign bus.mem_cen      = mem_cen_q;
    assign bus.mem_wen      = wen_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_wmask    = wmask_q;
    assign bus.mem_size     = size_q;
    assign bus.tmr_cen      = tmr_cen_q;
    assign bus.tmr_wen      = wen_q;
    assign bus.tmr_addr     = addr_q;
    assign bus.tmr_wdata    = wdata_q;

endmodule
